// File: rtl/exc_irq_ctrl_pkg.sv
// Shared encodings for the exception/interrupt controller: cause codes, cause-register
// codes and FSM states.
package exc_irq_ctrl_pkg;

  localparam logic [2:0] CAUSE_ILLEGAL = 3'b001;
  localparam logic [2:0] CAUSE_OVF     = 3'b010;
  localparam logic [2:0] CAUSE_SYSCALL = 3'b011;
  localparam logic [2:0] CAUSE_NONE    = 3'b100;

  localparam logic [3:0] CODE_DFAULT = 4'd0;
  localparam logic [3:0] CODE_IRQ0   = 4'd4;

  typedef enum logic [1:0] {
    StIdle,
    StTake,
    StHandler,
    StReturn
  } state_e;

  // Only the three real exception encodings count; 000 and 100..111 mean no event.
  function automatic logic is_sync(input logic [2:0] cause);
    return (cause == CAUSE_ILLEGAL) || (cause == CAUSE_OVF) || (cause == CAUSE_SYSCALL);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt controller at the step-4 commit point.
// Define IRQ_EDGE_EN for edge-latched interrupt lines; default is level mode.
module exc_irq_ctrl
  import exc_irq_ctrl_pkg::*;
#(
  parameter int unsigned          NUM_IRQ   = 4,
  parameter int unsigned          ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]    VEC_BASE  = '0,
  parameter int unsigned          VEC_SHIFT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         cause_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               eret_i,
  input  logic               mask_we_i,
  input  logic [NUM_IRQ-1:0] mask_i,
  output logic               take_o,
  output logic [ADDR_W-1:0]  vec_o,
  output logic               ret_o,
  output logic [ADDR_W-1:0]  epc_o,
  output logic [3:0]         code_o,
  output logic               busy_o,
  output logic [NUM_IRQ-1:0] pend_o
);

  state_e              state_q;
  logic                take_q, ret_q, busy_q;
  logic [ADDR_W-1:0]   epc_q, vec_q;
  logic [3:0]          code_q, code_sel;
  logic [NUM_IRQ-1:0]  mask_q, pend, req;
  logic                req_valid, sync_evt, take_ext;
  logic [2:0]          req_idx;

  function automatic logic [ADDR_W-1:0] vec_of(input logic [3:0] code);
    return VEC_BASE + (ADDR_W'(code) << VEC_SHIFT);
  endfunction

  assign req      = pend & mask_q;
  assign sync_evt = is_sync(cause_i);
  assign take_ext = (state_q == StIdle) && !sync_evt && req_valid;
  assign code_sel = sync_evt ? {1'b0, cause_i} : (CODE_IRQ0 + {1'b0, req_idx});

  irq_prio_enc #(
    .N(NUM_IRQ)
  ) u_prio (
    .req  (req),
    .valid(req_valid),
    .idx  (req_idx)
  );

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] pend_q, irq_prev_q, clr;

  assign clr = take_ext ? (NUM_IRQ'(1) << req_idx) : '0;

  // A fresh rising edge wins over the clear of a line being taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= '0;
      irq_prev_q <= '0;
    end else begin
      pend_q     <= (pend_q & ~clr) | (irq_i & ~irq_prev_q);
      irq_prev_q <= irq_i;
    end
  end

  assign pend   = pend_q;
  assign pend_o = pend_q;
`else
  assign pend   = irq_i;
  assign pend_o = irq_i & mask_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      take_q  <= 1'b0;
      ret_q   <= 1'b0;
      busy_q  <= 1'b0;
      epc_q   <= '0;
      vec_q   <= '0;
      code_q  <= '0;
      mask_q  <= '1;
    end else begin
      if (mask_we_i) mask_q <= mask_i;
      take_q <= 1'b0;
      ret_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (sync_evt || req_valid) begin
            state_q <= StTake;
            epc_q   <= pc_i;
            code_q  <= code_sel;
            vec_q   <= vec_of(code_sel);
            take_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StTake: state_q <= StHandler;
        StHandler: begin
          if (sync_evt) begin
            state_q <= StTake;
            code_q  <= CODE_DFAULT;
            vec_q   <= vec_of(CODE_DFAULT);
            take_q  <= 1'b1;
          end else if (eret_i) begin
            state_q <= StReturn;
            ret_q   <= 1'b1;
          end
        end
        StReturn: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign take_o = take_q;
  assign ret_o  = ret_q;
  assign busy_o = busy_q;
  assign epc_o  = epc_q;
  assign vec_o  = vec_q;
  assign code_o = code_q;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Directed bench for exc_irq_ctrl (default parameters; works in level or IRQ_EDGE_EN mode).
module tb_exc_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cause_i;
  logic [15:0] pc_i;
  logic [3:0]  irq_i;
  logic        eret_i;
  logic        mask_we_i;
  logic [3:0]  mask_i;
  logic        take_o, ret_o, busy_o;
  logic [15:0] vec_o, epc_o;
  logic [3:0]  code_o, pend_o;

  int n_checks = 0;
  int n_fail   = 0;

  exc_irq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cause_i  (cause_i),
    .pc_i     (pc_i),
    .irq_i    (irq_i),
    .eret_i   (eret_i),
    .mask_we_i(mask_we_i),
    .mask_i   (mask_i),
    .take_o   (take_o),
    .vec_o    (vec_o),
    .ret_o    (ret_o),
    .epc_o    (epc_o),
    .code_o   (code_o),
    .busy_o   (busy_o),
    .pend_o   (pend_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_take(input string tag);
    int n = 0;
    while (!take_o && n < 8) begin
      tick();
      n++;
    end
    check_eq(tag, take_o, 1);
  endtask

  // Called in the TAKE cycle: walks HANDLER -> RETURN -> IDLE.
  task automatic do_return(input string tag, input logic [15:0] exp_epc, input int hold);
    tick();
    check_eq({tag, "_handler_take"}, take_o, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq({tag, "_hold_take"}, take_o, 0);
      check_eq({tag, "_hold_busy"}, busy_o, 1);
    end
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
    check_eq({tag, "_ret"}, ret_o, 1);
    check_eq({tag, "_ret_epc"}, epc_o, exp_epc);
    tick();
    check_eq({tag, "_ret_done"}, ret_o, 0);
    check_eq({tag, "_idle_busy"}, busy_o, 0);
  endtask

  initial begin
    reset = 1'b1; cause_i = 3'b100; pc_i = '0; irq_i = '0;
    eret_i = 1'b0; mask_we_i = 1'b0; mask_i = '0;
    tick(); tick();
    check_eq("rst_take", take_o, 0);
    check_eq("rst_ret", ret_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_code", code_o, 0);
    check_eq("rst_epc", epc_o, 0);
    check_eq("rst_vec", vec_o, 0);
    check_eq("rst_pend", pend_o, 0);
    reset = 1'b0;
    tick();

    // 1: ALU overflow
    cause_i = 3'b010; pc_i = 16'h0040;
    tick();
    cause_i = 3'b100;
    check_eq("t1_take", take_o, 1);
    check_eq("t1_code", code_o, 2);
    check_eq("t1_vec", vec_o, 16'h0004);
    check_eq("t1_epc", epc_o, 16'h0040);
    check_eq("t1_busy", busy_o, 1);
    do_return("t1", 16'h0040, 0);

    // 2: two lines, lowest index first, second taken after return
    irq_i = 4'b0110; pc_i = 16'h0050;
    wait_take("t2a_take");
    check_eq("t2a_code", code_o, 5);
    check_eq("t2a_vec", vec_o, 16'h000a);
`ifdef IRQ_EDGE_EN
    check_eq("t2a_pend", pend_o, 4'b0100);
`else
    check_eq("t2a_pend", pend_o, 4'b0110);
`endif
    irq_i = 4'b0100;
    do_return("t2a", 16'h0050, 1);
    wait_take("t2b_take");
    check_eq("t2b_code", code_o, 6);
    check_eq("t2b_vec", vec_o, 16'h000c);
    irq_i = 4'b0000;
    do_return("t2b", 16'h0050, 0);

    // 3: syscall beats irq0 in the same cycle
    cause_i = 3'b011; irq_i = 4'b0001; pc_i = 16'h0080;
    tick();
    cause_i = 3'b100;
    check_eq("t3a_take", take_o, 1);
    check_eq("t3a_code", code_o, 3);
    check_eq("t3a_vec", vec_o, 16'h0006);
    check_eq("t3a_epc", epc_o, 16'h0080);
    do_return("t3a", 16'h0080, 0);
    wait_take("t3b_take");
    check_eq("t3b_code", code_o, 4);
    check_eq("t3b_vec", vec_o, 16'h0008);
    irq_i = 4'b0000;
    do_return("t3b", 16'h0080, 0);

    // 4: exception with eret in HANDLER -> double fault
    cause_i = 3'b010; pc_i = 16'h0100;
    tick();
    cause_i = 3'b100;
    check_eq("t4a_code", code_o, 2);
    tick();
    cause_i = 3'b001; eret_i = 1'b1; pc_i = 16'h0200;
    tick();
    cause_i = 3'b100; eret_i = 1'b0;
    check_eq("t4_take", take_o, 1);
    check_eq("t4_code", code_o, 0);
    check_eq("t4_vec", vec_o, 16'h0000);
    check_eq("t4_epc", epc_o, 16'h0100);
    check_eq("t4_noret", ret_o, 0);
    do_return("t4", 16'h0100, 0);

    // 5: masked line latches (edge) but is not taken until unmasked
    mask_we_i = 1'b1; mask_i = 4'b1110;
    tick();
    mask_we_i = 1'b0;
    irq_i = 4'b0001;
    tick();
`ifdef IRQ_EDGE_EN
    irq_i = 4'b0000;
`endif
    tick(); tick();
    check_eq("t5_notake", take_o, 0);
    check_eq("t5_idle", busy_o, 0);
`ifdef IRQ_EDGE_EN
    check_eq("t5_pend", pend_o, 4'b0001);
`else
    check_eq("t5_pend", pend_o, 4'b0000);
`endif
    mask_we_i = 1'b1; mask_i = 4'b1111;
    tick();
    mask_we_i = 1'b0;
    wait_take("t5_take");
    check_eq("t5_code", code_o, 4);
`ifdef IRQ_EDGE_EN
    check_eq("t5_pend_clr", pend_o, 4'b0000);
`else
    check_eq("t5_pend_lvl", pend_o, 4'b0001);
`endif
    irq_i = 4'b0000;
    do_return("t5", 16'h0200, 0);

    // 6: async reset in TAKE; mask returns to all ones
    mask_we_i = 1'b1; mask_i = 4'b0000;
    tick();
    mask_we_i = 1'b0;
    cause_i = 3'b011; irq_i = 4'b1000;
    tick();
    cause_i = 3'b100;
    check_eq("t6_take", take_o, 1);
`ifndef IRQ_EDGE_EN
    irq_i = 4'b0000;
`endif
    reset = 1'b1;
    #1;
    check_eq("t6_rst_take", take_o, 0);
    check_eq("t6_rst_busy", busy_o, 0);
    check_eq("t6_rst_pend", pend_o, 0);
    check_eq("t6_rst_code", code_o, 0);
    tick();
    reset = 1'b0;
    irq_i = 4'b1000;
    wait_take("t6_mask_take");
    check_eq("t6_mask_code", code_o, 7);
    check_eq("t6_mask_vec", vec_o, 16'h000e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
